// File: rtl/cv32e40p_voter_tracked.sv
// Registered TMR voter that blames the odd replica, retires it after repeated faults and falls back to DMR compare.
// Optional per-replica error counters are built when CV32E40P_VOTER_ERR_CNT_EN is defined.
//   state    | meaning
//   MODE_TMR | all three replicas voted
//   MODE_DMR | one replica retired, remaining pair compared
module cv32e40p_voter_tracked #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DISABLE_THRESH = 4,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       res1_i,
    input  logic [WIDTH-1:0]       res2_i,
    input  logic [WIDTH-1:0]       res3_i,
    input  logic                   clear_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       result_o,
    output logic                   faulty_o,
    output logic [2:0]             fault_id_o,
    output logic                   uncorr_o,
    output logic                   uncorr_sticky_o,
    output logic [2:0]             retired_o,
    output logic                   dmr_mode_o,
    output logic [3*ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic {MODE_TMR, MODE_DMR} mode_e;

    localparam logic [3:0] THRESH = 4'(DISABLE_THRESH);

    mode_e            mode_q, mode_d;
    logic [2:0]       retired_q, retired_d;
    logic [3:0]       cons_q [3];
    logic [3:0]       cons_d [3];

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             faulty_q;
    logic [2:0]       fault_id_q;
    logic             uncorr_q;
    logic             sticky_q;

    logic             eq12, eq13, eq23;
    logic [WIDTH-1:0] vote_res;
    logic             vote_fault, vote_unc;
    logic [2:0]       vote_blame, vote_match;
    logic [WIDTH-1:0] dmr_a, dmr_b;
    logic [2:0]       dmr_active;
    logic             count_en;

    assign eq12 = (res1_i == res2_i);
    assign eq13 = (res1_i == res3_i);
    assign eq23 = (res2_i == res3_i);

    // vote_match marks active replicas that agree with the voted value; their streaks restart
    always_comb begin
        vote_res   = res1_i;
        vote_fault = 1'b0;
        vote_unc   = 1'b0;
        vote_blame = 3'b000;
        vote_match = 3'b000;
        dmr_a      = res1_i;
        dmr_b      = res2_i;
        dmr_active = 3'b011;
        if (retired_q[0]) begin
            dmr_a      = res2_i;
            dmr_b      = res3_i;
            dmr_active = 3'b110;
        end else if (retired_q[1]) begin
            dmr_b      = res3_i;
            dmr_active = 3'b101;
        end
        if (mode_q == MODE_DMR) begin
            vote_res = dmr_a;
            if (dmr_a == dmr_b) begin
                vote_match = dmr_active;
            end else begin
                vote_fault = 1'b1;
                vote_unc   = 1'b1;
            end
        end else if (eq12 && eq13) begin
            vote_match = 3'b111;
        end else if (eq12) begin
            vote_fault = 1'b1;
            vote_blame = 3'b100;
            vote_match = 3'b011;
        end else if (eq13) begin
            vote_fault = 1'b1;
            vote_blame = 3'b010;
            vote_match = 3'b101;
        end else if (eq23) begin
            vote_res   = res2_i;
            vote_fault = 1'b1;
            vote_blame = 3'b001;
            vote_match = 3'b110;
        end else begin
            vote_res   = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);
            vote_fault = 1'b1;
            vote_unc   = 1'b1;
        end
    end

    assign count_en = valid_i & ~clear_i & ~vote_unc;

    always_comb begin
        mode_d    = mode_q;
        retired_d = retired_q;
        for (int i = 0; i < 3; i++) cons_d[i] = cons_q[i];
        if (clear_i) begin
            mode_d    = MODE_TMR;
            retired_d = 3'b000;
            for (int i = 0; i < 3; i++) cons_d[i] = 4'd0;
        end else if (count_en) begin
            for (int i = 0; i < 3; i++) begin
                if (vote_blame[i])
                    cons_d[i] = (cons_q[i] == 4'hF) ? 4'hF : cons_q[i] + 4'd1;
                else if (vote_match[i])
                    cons_d[i] = 4'd0;
            end
            if (mode_q == MODE_TMR) begin
                for (int i = 0; i < 3; i++) begin
                    if (vote_blame[i] && (cons_d[i] >= THRESH)) begin
                        mode_d    = MODE_DMR;
                        retired_d = vote_blame;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_TMR;
            retired_q  <= 3'b000;
            for (int i = 0; i < 3; i++) cons_q[i] <= 4'd0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            faulty_q   <= 1'b0;
            fault_id_q <= 3'b000;
            uncorr_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            retired_q <= retired_d;
            for (int i = 0; i < 3; i++) cons_q[i] <= cons_d[i];
            valid_q   <= valid_i;
            if (valid_i) begin
                result_q   <= vote_res;
                faulty_q   <= vote_fault;
                fault_id_q <= vote_blame;
                uncorr_q   <= vote_unc;
            end else begin
                faulty_q   <= 1'b0;
                fault_id_q <= 3'b000;
                uncorr_q   <= 1'b0;
            end
            if (clear_i)
                sticky_q <= 1'b0;
            else if (valid_i && vote_unc)
                sticky_q <= 1'b1;
        end
    end

`ifdef CV32E40P_VOTER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q [3];

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            for (int i = 0; i < 3; i++) err_cnt_q[i] <= '0;
        end else if (count_en) begin
            for (int i = 0; i < 3; i++) begin
                if (vote_blame[i] && (err_cnt_q[i] != {ERR_CNT_W{1'b1}}))
                    err_cnt_q[i] <= err_cnt_q[i] + ERR_CNT_W'(1);
            end
        end
    end

    assign err_cnt_o = {err_cnt_q[2], err_cnt_q[1], err_cnt_q[0]};
`else
    assign err_cnt_o = '0;
`endif

    assign valid_o         = valid_q;
    assign result_o        = result_q;
    assign faulty_o        = faulty_q;
    assign fault_id_o      = fault_id_q;
    assign uncorr_o        = uncorr_q;
    assign uncorr_sticky_o = sticky_q;
    assign retired_o       = retired_q;
    assign dmr_mode_o      = (mode_q == MODE_DMR);

endmodule

// File: tb/tb_cv32e40p_voter_tracked.sv
// Bench for cv32e40p_voter_tracked: directed scenarios plus a randomized run against a behavioural model.
module tb_cv32e40p_voter_tracked;

    localparam int WIDTH = 32;
    localparam int THRESH = 4;
    localparam int ECW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i;
    logic [WIDTH-1:0]  res1_i, res2_i, res3_i;
    logic              clear_i;
    logic              valid_o;
    logic [WIDTH-1:0]  result_o;
    logic              faulty_o;
    logic [2:0]        fault_id_o;
    logic              uncorr_o;
    logic              uncorr_sticky_o;
    logic [2:0]        retired_o;
    logic              dmr_mode_o;
    logic [3*ECW-1:0]  err_cnt_o;

    cv32e40p_voter_tracked #(.WIDTH(WIDTH), .DISABLE_THRESH(THRESH), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
        .res1_i(res1_i), .res2_i(res2_i), .res3_i(res3_i), .clear_i(clear_i),
        .valid_o(valid_o), .result_o(result_o), .faulty_o(faulty_o), .fault_id_o(fault_id_o),
        .uncorr_o(uncorr_o), .uncorr_sticky_o(uncorr_sticky_o), .retired_o(retired_o),
        .dmr_mode_o(dmr_mode_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state: retired replica index (0 = none, 1..3), streaks, error totals
    int m_ret;
    int m_cons [3];
    int m_err [3];

    logic             exp_valid;
    logic [WIDTH-1:0] exp_result;
    logic             exp_faulty;
    logic [2:0]       exp_id;
    logic             exp_unc;
    logic             exp_sticky;
    logic [2:0]       exp_ret;
    logic             exp_dmr;
    logic [3*ECW-1:0] exp_err;

    localparam int VEC_W = 1 + WIDTH + 1 + 3 + 1 + 1 + 3 + 1 + 3*ECW;
    logic [VEC_W-1:0] got_vec, exp_vec;

    task automatic model_step(input logic v, input logic [WIDTH-1:0] a, b, c,
                              input logic clr, input logic rstn);
        logic [WIDTH-1:0] r [3];
        logic [WIDTH-1:0] res;
        int agree [3];
        int blame, nzero, ones, first, second;
        logic unc, flt;
        r[0] = a; r[1] = b; r[2] = c;
        if (!rstn) begin
            m_ret = 0;
            for (int i = 0; i < 3; i++) begin m_cons[i] = 0; m_err[i] = 0; end
            exp_valid = 0; exp_result = '0; exp_faulty = 0; exp_id = 0;
            exp_unc = 0; exp_sticky = 0;
        end else begin
            blame = 0; unc = 0; flt = 0; res = r[0];
            if (m_ret == 0) begin
                nzero = 0;
                for (int i = 0; i < 3; i++) begin
                    agree[i] = 0;
                    for (int j = 0; j < 3; j++)
                        if (j != i && r[i] == r[j]) agree[i]++;
                    if (agree[i] == 0) nzero++;
                end
                if (nzero == 1) begin
                    flt = 1;
                    for (int i = 0; i < 3; i++) begin
                        if (agree[i] == 0) blame = i + 1;
                        else res = r[i];
                    end
                end else if (nzero == 3) begin
                    flt = 1; unc = 1;
                    for (int k = 0; k < WIDTH; k++) begin
                        ones = int'(r[0][k]) + int'(r[1][k]) + int'(r[2][k]);
                        res[k] = (ones >= 2);
                    end
                end
            end else begin
                first = (m_ret == 1) ? 1 : 0;
                second = (m_ret == 3) ? 1 : 2;
                res = r[first];
                if (r[first] != r[second]) begin flt = 1; unc = 1; end
            end
            exp_valid = v;
            if (v) begin
                exp_result = res; exp_faulty = flt; exp_unc = unc;
                exp_id = (blame == 0) ? 3'b000 : 3'(1 << (blame - 1));
            end else begin
                exp_faulty = 0; exp_unc = 0; exp_id = 0;
            end
            if (clr) begin
                m_ret = 0; exp_sticky = 0;
                for (int i = 0; i < 3; i++) begin m_cons[i] = 0; m_err[i] = 0; end
            end else if (v) begin
                if (unc) exp_sticky = 1;
                else begin
                    for (int i = 0; i < 3; i++) begin
                        if (blame == i + 1) begin
                            if (m_cons[i] < 15) m_cons[i]++;
                            if (m_err[i] < 255) m_err[i]++;
                        end else if (m_ret != i + 1 && r[i] == res) m_cons[i] = 0;
                    end
                    if (blame != 0 && m_ret == 0 && m_cons[blame-1] >= THRESH) m_ret = blame;
                end
            end
        end
        exp_ret = (m_ret == 0) ? 3'b000 : 3'(1 << (m_ret - 1));
        exp_dmr = (m_ret != 0);
`ifdef CV32E40P_VOTER_ERR_CNT_EN
        exp_err = {8'(m_err[2]), 8'(m_err[1]), 8'(m_err[0])};
`else
        exp_err = '0;
`endif
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, b, c, input logic clr);
        valid_i = v; res1_i = a; res2_i = b; res3_i = c; clear_i = clr;
        model_step(v, a, b, c, clr, rst_n);
        @(posedge clk);
        #1;
        got_vec = {valid_o, result_o, faulty_o, fault_id_o, uncorr_o, uncorr_sticky_o,
                   retired_o, dmr_mode_o, err_cnt_o};
        exp_vec = {exp_valid, exp_result, exp_faulty, exp_id, exp_unc, exp_sticky,
                   exp_ret, exp_dmr, exp_err};
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(1, 32'h1234, 32'h1234, 32'h9, 0);
        drive(1, 32'h1, 32'h2, 32'h3, 0);
        checks++;
        if (got_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", got_vec);
        end
        rst_n = 1;
    endtask

    task automatic test_agreement();
        drive(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
        checks++;
        if ({valid_o, result_o, faulty_o, fault_id_o} !== {1'b1, 32'hA5A5A5A5, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL agreement: got v=%b r=%h f=%b id=%b", valid_o, result_o, faulty_o, fault_id_o);
        end
    endtask

    task automatic test_single_fault();
        drive(1, 32'h0, 32'h1, 32'h0, 0);
        checks++;
        if ({result_o, faulty_o, fault_id_o, uncorr_o} !== {32'h0, 1'b1, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL single_fault: got r=%h f=%b id=%b u=%b", result_o, faulty_o, fault_id_o, uncorr_o);
        end
        checks++;
`ifdef CV32E40P_VOTER_ERR_CNT_EN
        if (err_cnt_o !== 24'h000100) begin
`else
        if (err_cnt_o !== 24'h0) begin
`endif
            errors++;
            $display("FAIL single_fault_errcnt: got %h", err_cnt_o);
        end
    endtask

    task automatic test_retirement();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h10, 32'h10, 32'h11 + k, 0);
            checks++;
            if ({retired_o, dmr_mode_o, result_o, fault_id_o} !==
                {(k == 3) ? 3'b100 : 3'b000, k == 3, 32'h10, 3'b100}) begin
                errors++;
                $display("FAIL retire_step%0d: got ret=%b dmr=%b r=%h id=%b", k, retired_o, dmr_mode_o, result_o, fault_id_o);
            end
        end
        drive(1, 32'h5, 32'h5, 32'h9, 0);
        checks++;
        if ({result_o, faulty_o, fault_id_o, uncorr_o, dmr_mode_o} !== {32'h5, 1'b0, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL dmr_ignore_retired: got r=%h f=%b id=%b u=%b", result_o, faulty_o, fault_id_o, uncorr_o);
        end
    endtask

    task automatic test_counter_reset();
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(1, 32'h7, 32'h7, 32'h8, 0);
        drive(1, 32'h7, 32'h7, 32'h7, 0);
        for (int k = 0; k < 3; k++) drive(1, 32'h7, 32'h7, 32'h8, 0);
        checks++;
        if (retired_o !== 3'b000 || dmr_mode_o !== 1'b0) begin
            errors++;
            $display("FAIL counter_reset: got ret=%b dmr=%b required 000/0", retired_o, dmr_mode_o);
        end
        drive(1, 32'h7, 32'h7, 32'h8, 0);
        checks++;
        if (retired_o !== 3'b100 || dmr_mode_o !== 1'b1) begin
            errors++;
            $display("FAIL counter_threshold: got ret=%b dmr=%b required 100/1", retired_o, dmr_mode_o);
        end
    endtask

    task automatic test_uncorrectable();
        drive(0, 0, 0, 0, 1);
        drive(1, 32'h3, 32'h5, 32'h6, 0);
        checks++;
        if ({result_o, uncorr_o, uncorr_sticky_o, faulty_o, fault_id_o} !== {32'h7, 1'b1, 1'b1, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL uncorr_tmr: got r=%h u=%b s=%b f=%b id=%b", result_o, uncorr_o, uncorr_sticky_o, faulty_o, fault_id_o);
        end
        for (int k = 0; k < 4; k++) drive(1, 32'h20, 32'h20, 32'h21, 0);
        drive(1, 32'h1, 32'h2, 32'hFF, 0);
        checks++;
        if ({result_o, uncorr_o, faulty_o, fault_id_o, dmr_mode_o} !== {32'h1, 1'b1, 1'b1, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL uncorr_dmr: got r=%h u=%b f=%b id=%b dmr=%b", result_o, uncorr_o, faulty_o, fault_id_o, dmr_mode_o);
        end
    endtask

    task automatic test_clear_vs_valid();
        drive(1, 32'h1, 32'h2, 32'h3, 1);
        checks++;
        if ({valid_o, result_o, uncorr_o, dmr_mode_o, retired_o, uncorr_sticky_o, err_cnt_o} !==
            {1'b1, 32'h1, 1'b1, 1'b0, 3'b000, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL clear_with_valid: got r=%h u=%b dmr=%b ret=%b s=%b err=%h",
                     result_o, uncorr_o, dmr_mode_o, retired_o, uncorr_sticky_o, err_cnt_o);
        end
        drive(1, 32'h0, 32'h0, 32'h1, 0);
        checks++;
        if ({result_o, fault_id_o} !== {32'h0, 3'b100}) begin
            errors++;
            $display("FAIL tmr_after_clear: got r=%h id=%b", result_o, fault_id_o);
        end
        rst_n = 0;
        drive(1, 32'h3, 32'h5, 32'h6, 0);
        checks++;
        if (got_vec !== '0) begin
            errors++;
            $display("FAIL midstream_reset: got %h required 0", got_vec);
        end
        rst_n = 1;
    endtask

    task automatic test_idle_hold();
        drive(1, 32'hBEEF, 32'hBEEF, 32'h1, 0);
        drive(0, 32'h1, 32'h2, 32'h3, 0);
        checks++;
        if ({valid_o, result_o, faulty_o, fault_id_o, uncorr_o} !== {1'b0, 32'hBEEF, 1'b0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got v=%b r=%h f=%b id=%b u=%b", valid_o, result_o, faulty_o, fault_id_o, uncorr_o);
        end
    endtask

    task automatic test_err_saturate();
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 540; k++) begin
            if (k[0]) drive(1, 32'h0, 32'h1, 32'h0, 0);
            else      drive(1, 32'h1, 32'h0, 32'h0, 0);
        end
        checks++;
        if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL err_saturate: got %h required %h", got_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, c, base;
        int sel, odd;
        for (int n = 0; n < 600; n++) begin
            sel  = $urandom_range(0, 9);
            base = $urandom;
            a = base; b = base; c = base;
            if (sel >= 5 && sel <= 7) begin
                odd = $urandom_range(0, 2);
                if (odd == 0) a = base ^ 32'(1 << $urandom_range(0, 31));
                else if (odd == 1) b = base ^ 32'(1 << $urandom_range(0, 31));
                else c = base ^ 32'(1 << $urandom_range(0, 31));
            end else if (sel >= 8) begin
                a = 32'($urandom_range(0, 7));
                b = 32'($urandom_range(0, 7));
                c = 32'($urandom_range(0, 7));
            end
            drive($urandom_range(0, 7) != 0, a, b, c, $urandom_range(0, 39) == 0);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_%0d: got %h required %h", n, got_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst_n = 0; valid_i = 0; clear_i = 0; res1_i = '0; res2_i = '0; res3_i = '0;
        m_ret = 0;
        for (int i = 0; i < 3; i++) begin m_cons[i] = 0; m_err[i] = 0; end
        test_reset();
        test_agreement();
        test_single_fault();
        test_retirement();
        test_counter_reset();
        test_uncorrectable();
        test_clear_vs_valid();
        test_idle_hold();
        test_err_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_voter_tracked.md
Name: cv32e40p_voter_tracked

Overview:
- Registered, parametrised TMR voter with fault tracking.
- Votes three replica results bitwise, identifies the faulty replica and counts consecutive faults per replica.
- Permanently retires a replica that reaches a threshold, then drops to duplex (DMR) compare mode.
- Sits at the output of triplicated datapath units (ALU/LSU/CSR results); feeds the fault-status CSR and recovery logic.

Parameters:
- WIDTH, 32, width of each replica result.
- DISABLE_THRESH, 4, consecutive faults of one replica that retire it; legal range 1..15.
- ERR_CNT_W, 8, width of each per-replica saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  replica results valid this cycle.
- res1_i  in  WIDTH  replica 1 result.
- res2_i  in  WIDTH  replica 2 result.
- res3_i  in  WIDTH  replica 3 result.
- clear_i  in  1  clear all sticky status, counters and retirement.
- valid_o  out  1  result_o valid (1-cycle latency).
- result_o  out  WIDTH  voted result.
- faulty_o  out  1  the sample in result_o had a mismatch.
- fault_id_o  out  3  one-hot replica blamed for the sample in result_o; 0 if none or unidentifiable.
- uncorr_o  out  1  the sample in result_o had no majority; result not trustworthy.
- uncorr_sticky_o  out  1  set by any uncorr_o event; cleared only by reset or clear_i.
- retired_o  out  3  one-hot retired replica; at most one bit set.
- dmr_mode_o  out  1  1 when in DMR.
- err_cnt_o  out  3*ERR_CNT_W  per-replica error counters; replica 1 in the LSBs.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state TMR, all counters 0.
- Latency: a sample presented with valid_i=1 appears on result_o and the status outputs in the next cycle with valid_o=1.
- Cycle with valid_i=0: valid_o=0, faulty_o, fault_id_o and uncorr_o are 0, result_o holds its last value, no counter or state changes.
- State TMR classification:
  - All three replicas equal: result=res1, no fault.
  - Exactly one replica differs from the two agreeing ones: result=agreeing value, faulty_o=1, fault_id_o=that replica.
  - All pairwise different: result=bitwise majority (res1&res2 | res1&res3 | res2&res3), faulty_o=1, uncorr_o=1, fault_id_o=0.
- State DMR (one replica retired): compare the two remaining replicas; the retired replica is ignored entirely.
  - Equal: output the value, no fault.
  - Different: result=lower-index remaining replica, faulty_o=1, uncorr_o=1, fault_id_o=0.
- Consecutive counters (4 bits per replica), updated on valid samples only:
  - The blamed replica increments, saturating at 15.
  - Every other active replica whose value matched result resets to 0.
  - On an uncorrectable sample, all consecutive counters hold.
- Retirement, TMR->DMR:
  - Triggered when a blamed replica's consecutive count reaches DISABLE_THRESH, counting the current sample.
  - retired_o and dmr_mode_o are set in the same cycle as that sample's outputs.
  - Output for that sample is still the TMR vote.
- DMR->TMR: only by reset or clear_i. No further retirement is possible in DMR.
- Error counters: increment for the blamed replica on each attributable fault; saturate at 2^ERR_CNT_W-1, no wrap.
- clear_i=1: next cycle state=TMR; retired_o, uncorr_sticky_o and all counters are 0.
- clear_i together with valid_i:
  - The sample is voted in the pre-clear mode, and its per-sample outputs are produced normally.
  - Its fault is not counted, and uncorr_sticky_o is not set by it.
- Reset mid-stream: the in-flight sample is dropped (valid_o=0 after reset).

Optional Feature:
- Macro: CV32E40P_VOTER_ERR_CNT_EN.
- Defined: the per-replica ERR_CNT_W saturating error counters are implemented and driven on err_cnt_o.
- Undefined: no counter registers exist and err_cnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- Agreement: reset, then valid_i=1 with all replicas 0xA5A5A5A5 -> next cycle valid_o=1, result_o=0xA5A5A5A5, faulty_o=0, fault_id_o=000.
- Single fault: res2_i=0x00000001, others 0x0 -> result_o=0x0, faulty_o=1, fault_id_o=010. With the macro defined, replica 2's field in err_cnt_o=1.
- Retirement: res3_i differs on 4 consecutive valid samples (DISABLE_THRESH=4) -> on the 4th output, retired_o=100 and dmr_mode_o=1. A 5th sample with res1=res2=0x5 and res3=0x9 -> result 0x5, no fault.
- Counter reset: replica 3 faults on 3 samples, then 1 clean sample, then 3 more faults -> no retirement, retired_o=000.
- Uncorrectable: res1=0x3, res2=0x5, res3=0x6 in TMR -> result_o=0x7, uncorr_o=1, uncorr_sticky_o=1. Then in DMR with replica 3 retired, res1=0x1 and res2=0x2 -> result_o=0x1, uncorr_o=1.
- Clear vs valid: while in DMR, pulse clear_i together with a faulty sample -> that sample voted in DMR; next cycle dmr_mode_o=0, all counters 0, uncorr_sticky_o=0. A following rst_n=0 -> all outputs 0.
